// File: rtl/amo_pkg.sv
// AMO opcode encoding shared by the bank shim, the bank arbiter
// and the cores' request encoders.
package amo_pkg;

  localparam int AmoOpWidth = 4;

  typedef enum logic [AmoOpWidth-1:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOCAS  = 4'hA
  } amo_op_t;

endpackage

// File: rtl/rr_arb_core.sv
// Round-robin winner search: first asserted request at or after
// the pointer, wrapping modulo NumPorts (any NumPorts >= 1).
module rr_arb_core #(
  parameter int NumPorts = 4,
  parameter int IdxWidth = 2
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  localparam int PadW = 2 ** IdxWidth;

  logic [PadW-1:0]   req_pad;
  logic [IdxWidth:0] cand;

  // Walk offsets from far to near so the nearest hit overwrites.
  always_comb begin
    req_pad = '0;
    req_pad[NumPorts-1:0] = req_i;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + (IdxWidth+1)'(i);
      if (cand >= (IdxWidth+1)'(NumPorts))
        cand = cand - (IdxWidth+1)'(NumPorts);
      if (req_pad[cand[IdxWidth-1:0]]) begin
        idx_o   = cand[IdxWidth-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amo_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank (behind its AMO shim)
// between NumPorts requesters; routes the 1-cycle response back.
module amo_bank_arbiter
  import amo_pkg::*;
#(
  parameter  int NumPorts     = 4,
  parameter  int AddrMemWidth = 32,
  parameter  int DataWidth    = 32,
  localparam int IdxWidth     = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int BeWidth      = DataWidth / 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumPorts-1:0]                    req_i,
  output logic [NumPorts-1:0]                    gnt_o,
  input  logic [NumPorts-1:0][AddrMemWidth-1:0]  add_i,
  input  logic [NumPorts-1:0][AmoOpWidth-1:0]    amo_i,
  input  logic [NumPorts-1:0]                    wen_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]       be_i,
  output logic [NumPorts-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                   rdata_o,
  output logic                                   bank_req_o,
  input  logic                                   bank_gnt_i,
  output logic [AddrMemWidth-1:0]                bank_add_o,
  output logic [AmoOpWidth-1:0]                  bank_amo_o,
  output logic                                   bank_wen_o,
  output logic [DataWidth-1:0]                   bank_wdata_o,
  output logic [BeWidth-1:0]                     bank_be_o,
  input  logic [DataWidth-1:0]                   bank_rdata_i
);

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] resp_idx_q;
  logic                resp_valid_q;
  logic [IdxWidth-1:0] win;
  logic                win_valid;
  logic                hs;

  rr_arb_core #(
    .NumPorts (NumPorts),
    .IdxWidth (IdxWidth)
  ) u_rr_arb_core (
    .req_i   (req_i),
    .ptr_i   (rr_q),
    .idx_o   (win),
    .valid_o (win_valid)
  );

  // Request is independent of bank_gnt_i; the grant path stays loop-free.
  assign bank_req_o = |req_i;
  assign hs         = bank_req_o & bank_gnt_i;

  // With no request win is 0, so port 0's fields are driven.
  assign bank_add_o   = add_i[win];
  assign bank_amo_o   = amo_i[win];
  assign bank_wen_o   = wen_i[win];
  assign bank_wdata_o = wdata_i[win];
  assign bank_be_o    = be_i[win];
  assign rdata_o      = bank_rdata_i;

  always_comb begin
    gnt_o      = '0;
    gnt_o[win] = hs & win_valid;
  end

  assign rr_d = (win == IdxWidth'(NumPorts - 1)) ? '0
              : win + IdxWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
    end else begin
      resp_valid_q <= hs;
      if (hs) begin
        rr_q       <= rr_d;
        resp_idx_q <= win;
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NumPorts; i++)
      rvalid_o[i] = resp_valid_q & (resp_idx_q == IdxWidth'(i));
  end

  a_gnt_onehot : assert property (
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

  a_rvalid_onehot : assert property (
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));

  a_amo_bubble : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (hs && bank_amo_o != AMONone) |=> (gnt_o == '0));

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// Randomized bench for amo_bank_arbiter: bank shim model plus a
// port-level reference of arbitration, bubbles and memory contents.
module tb_amo_bank_arbiter;
  import amo_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [NP-1:0]         req_i, gnt_o, wen_i, rvalid_o;
  logic [NP-1:0][AW-1:0] add_i;
  logic [NP-1:0][3:0]    amo_i;
  logic [NP-1:0][DW-1:0] wdata_i;
  logic [NP-1:0][BW-1:0] be_i;
  logic [DW-1:0]         rdata_o, bank_wdata_o, bank_rdata_i;
  logic                  bank_req_o, bank_gnt_i, bank_wen_o;
  logic [AW-1:0]         bank_add_o;
  logic [3:0]            bank_amo_o;
  logic [BW-1:0]         bank_be_o;

  amo_bank_arbiter #(
    .NumPorts (NP), .AddrMemWidth (AW), .DataWidth (DW)
  ) dut (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .req_i (req_i), .gnt_o (gnt_o), .add_i (add_i),
    .amo_i (amo_i), .wen_i (wen_i), .wdata_i (wdata_i),
    .be_i (be_i), .rvalid_o (rvalid_o), .rdata_o (rdata_o),
    .bank_req_o (bank_req_o), .bank_gnt_i (bank_gnt_i),
    .bank_add_o (bank_add_o), .bank_amo_o (bank_amo_o),
    .bank_wen_o (bank_wen_o), .bank_wdata_o (bank_wdata_o),
    .bank_be_o (bank_be_o), .bank_rdata_i (bank_rdata_i)
  );

  // Three-port instance for non-power-of-two wrap
  logic [2:0]         req3, gnt3, wen3, rvalid3;
  logic [2:0][AW-1:0] add3;
  logic [2:0][3:0]    amo3;
  logic [2:0][DW-1:0] wdata3;
  logic [2:0][BW-1:0] be3;
  logic [DW-1:0]      rdata3, bank_wdata3;
  logic               bank_req3, bank_gnt3, bank_wen3;
  logic [AW-1:0]      bank_add3;
  logic [3:0]         bank_amo3;
  logic [BW-1:0]      bank_be3;

  assign add3   = {AW'(2), AW'(1), AW'(0)};
  assign amo3   = '0;
  assign wen3   = '0;
  assign wdata3 = '0;
  assign be3    = '0;

  amo_bank_arbiter #(
    .NumPorts (3), .AddrMemWidth (AW), .DataWidth (DW)
  ) dut3 (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .req_i (req3), .gnt_o (gnt3), .add_i (add3),
    .amo_i (amo3), .wen_i (wen3), .wdata_i (wdata3),
    .be_i (be3), .rvalid_o (rvalid3), .rdata_o (rdata3),
    .bank_req_o (bank_req3), .bank_gnt_i (bank_gnt3),
    .bank_add_o (bank_add3), .bank_amo_o (bank_amo3),
    .bank_wen_o (bank_wen3), .bank_wdata_o (bank_wdata3),
    .bank_be_o (bank_be3), .bank_rdata_i ('0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_init(int k);
    if (k == 16) return 32'hDEAD;
    if (k == 32) return 32'd10;
    return 32'(k) * 32'h0101_0101 + 32'd3;
  endfunction

  function automatic logic [DW-1:0] amo_apply(
    logic [3:0] op, logic wen, logic [BW-1:0] be,
    logic [DW-1:0] old, logic [DW-1:0] wd);
    logic [DW-1:0] r;
    r = old;
    case (op)
      4'h0: if (wen)
              for (int b = 0; b < BW; b++)
                if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      4'h1: r = wd;
      4'h2: r = old + wd;
      4'h3: r = old & wd;
      4'h4: r = old | wd;
      4'h5: r = old ^ wd;
      4'h6: r = ($signed(old) > $signed(wd)) ? old : wd;
      4'h7: r = (old > wd) ? old : wd;
      4'h8: r = ($signed(old) < $signed(wd)) ? old : wd;
      4'h9: r = (old < wd) ? old : wd;
      default: r = old;
    endcase
    return r;
  endfunction

  // Bank shim model: driven only by the DUT's bank-side outputs
  logic [DW-1:0] shim_mem [64];
  logic          bubble_q;
  logic          gnt_rand;

  assign bank_gnt_i = gnt_rand & ~bubble_q;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bubble_q     <= 1'b0;
      bank_rdata_i <= '0;
      for (int k = 0; k < 64; k++) shim_mem[k] <= mem_init(k);
    end else begin
      bubble_q <= bank_req_o & bank_gnt_i & (bank_amo_o != 4'h0);
      if (bank_req_o & bank_gnt_i) begin
        bank_rdata_i <= shim_mem[bank_add_o[5:0]];
        shim_mem[bank_add_o[5:0]] <= amo_apply(bank_amo_o,
          bank_wen_o, bank_be_o, shim_mem[bank_add_o[5:0]],
          bank_wdata_o);
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  int            ptr, ptr3;
  logic          model_bubble;
  logic [NP-1:0] exp_rv, granted;
  logic [2:0]    exp_rv3;
  logic [DW-1:0] exp_rdata;

  task automatic do_reset();
    rst_ni   = 1'b0;
    req_i    = '0;
    req3     = '0;
    add_i    = '0;
    amo_i    = '0;
    wen_i    = '0;
    wdata_i  = '0;
    be_i     = '0;
    gnt_rand = 1'b1;
    bank_gnt3 = 1'b1;
    #1;
    check("rst_rvalid", rvalid_o, '0);
    check("rst_gnt", gnt_o, '0);
    check("rst_rvalid3", rvalid3, '0);
    for (int k = 0; k < 64; k++) ref_mem[k] = mem_init(k);
    ptr = 0;
    ptr3 = 0;
    model_bubble = 1'b0;
    exp_rv = '0;
    exp_rv3 = '0;
    granted = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One cycle: entered at a negedge with inputs set, leaves at next negedge
  task automatic step();
    int w, w3, c;
    logic [NP-1:0] eg;
    logic [2:0] eg3;
    req3 = 3'($urandom_range(0, 7));
    bank_gnt3 = ($urandom_range(0, 3) != 0);
    #1;
    w = -1;
    for (int i = 0; i < NP; i++) begin
      c = (ptr + i) % NP;
      if (w < 0 && req_i[c]) w = c;
    end
    eg = '0;
    if (w >= 0 && gnt_rand && !model_bubble) eg[w] = 1'b1;
    check("gnt", gnt_o, eg);
    check("bank_req", bank_req_o, w >= 0);
    check("bank_add", bank_add_o, add_i[(w < 0) ? 0 : w]);
    check("bank_amo", bank_amo_o, amo_i[(w < 0) ? 0 : w]);
    check("bank_wdata", bank_wdata_o, wdata_i[(w < 0) ? 0 : w]);
    check("rvalid", rvalid_o, exp_rv);
    if (exp_rv != '0) check("rdata", rdata_o, exp_rdata);
    exp_rv = '0;
    model_bubble = 1'b0;
    granted = eg;
    if (eg != '0) begin
      exp_rv = eg;
      exp_rdata = ref_mem[add_i[w][5:0]];
      ref_mem[add_i[w][5:0]] = amo_apply(amo_i[w], wen_i[w],
        be_i[w], exp_rdata, wdata_i[w]);
      model_bubble = (amo_i[w] != 4'h0);
      ptr = (w + 1) % NP;
    end
    w3 = -1;
    for (int i = 0; i < 3; i++) begin
      c = (ptr3 + i) % 3;
      if (w3 < 0 && req3[c]) w3 = c;
    end
    eg3 = '0;
    if (w3 >= 0 && bank_gnt3) eg3[w3] = 1'b1;
    check("gnt3", gnt3, eg3);
    check("bank_add3", bank_add3, (w3 < 0) ? 0 : w3);
    check("rvalid3", rvalid3, exp_rv3);
    exp_rv3 = eg3;
    if (eg3 != '0) ptr3 = (w3 + 1) % 3;
    @(negedge clk_i);
  endtask

  task automatic new_req(int i);
    req_i[i]   = 1'b1;
    add_i[i]   = AW'($urandom_range(0, 15));
    amo_i[i]   = ($urandom_range(0, 3) == 0) ?
                 4'($urandom_range(1, 9)) : 4'h0;
    wen_i[i]   = 1'($urandom_range(0, 1));
    wdata_i[i] = $urandom;
    be_i[i]    = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_random();
    for (int i = 0; i < NP; i++)
      if (!req_i[i] || granted[i]) begin
        if ($urandom_range(0, 3) != 0) new_req(i);
        else req_i[i] = 1'b0;
      end
    gnt_rand = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();

    // Port 0 load of 0x10
    req_i[0] = 1'b1;
    add_i[0] = AW'(32'h10);
    step();
    req_i = '0;
    #1 check("t1_rdata", rdata_o, 32'hDEAD);
    check("t1_rvalid", rvalid_o, 4'b0001);
    step();

    // AMOAdd on port 1 racing a load on port 2
    req_i = 4'b0110;
    add_i[1] = AW'(32'h20);
    amo_i[1] = AMOAdd;
    wdata_i[1] = 32'd5;
    add_i[2] = AW'(32'h20);
    step();
    req_i[1] = 1'b0;
    #1 check("t3_bubble_gnt", gnt_o, '0);
    check("t3_old", rdata_o, 32'd10);
    step();
    step();
    req_i = '0;
    #1 check("t3_load", rdata_o, 32'd15);
    step();

    // Ports 0 and 3 swapping continuously
    req_i = 4'b1001;
    amo_i = '0;
    add_i[0] = AW'(5);
    add_i[3] = AW'(5);
    amo_i[0] = AMOSwap;
    amo_i[3] = AMOSwap;
    for (int n = 0; n < 8; n++) begin
      wdata_i[0] = $urandom;
      wdata_i[3] = $urandom;
      step();
    end

    // Reset in the AMO commit cycle
    req_i = 4'b0010;
    amo_i = '0;
    amo_i[1] = AMOAdd;
    add_i[1] = AW'(3);
    step();
    check("t5_pre_rvalid", rvalid_o, 4'b0010);
    do_reset();
    req_i[0] = 1'b1;
    add_i[0] = AW'(32'h10);
    step();
    req_i = '0;
    step();

    // All four loading back to back
    do_reset();
    req_i = '1;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NP; i++)
        if (granted[i]) add_i[i] = AW'($urandom_range(0, 15));
      step();
    end

    // Random traffic
    req_i = '0;
    granted = '0;
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
